// File: rtl/uart_rx_module.sv
// ---------------------------------------------------------------------------
// uart_rx_module
//   UART receiver, 16x oversampled from the system clock via a tick enable.
//   Frame: start bit, DATA_LENGTH data bits (LSB first), one parity bit,
//   STOPBITS stop bits. Each word is delivered with a one-cycle valid strobe
//   plus per-frame parity and framing error flags.
//
//   Optional build macro: UART_RX_MAJORITY_EN
//     defined   : every bit decision is a 2-of-3 vote over three oversample
//                 ticks (os 6/7/8 for start, 14/15/0 for the others)
//     undefined : single sample at os 7 (start) / os 15 (others)
//
// Ports
//   clk_in      in   system clock
//   reset       in   synchronous, active-high reset
//   rx          in   asynchronous serial input, idles high
//   data        out  last received word, LSB = first bit on the line
//   valid       out  one-cycle strobe, data/flags valid in this cycle
//   parity_err  out  parity mismatch in the strobed frame
//   frame_err   out  a stop bit was sampled low in the strobed frame
//   active      out  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx_module #(
    parameter int BASE_FREQUENCY_MHZ = 100,
    parameter int BAUDRATE           = 9600,
    parameter int DATA_LENGTH        = 8,
    parameter int STOPBITS           = 1,
    parameter int PARITY             = 0,
    parameter int DIVIDER            = BASE_FREQUENCY_MHZ * 1000000 / (BAUDRATE * 16)
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   rx,
    output logic [DATA_LENGTH-1:0] data,
    output logic                   valid,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   active
);

    localparam int DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one tick after mid-bit; reloading os with 1 after the
    // start decision keeps the 14/15/0 window centred on each later bit.
    localparam logic [3:0] START_OS     = 4'd8;
    localparam logic [3:0] BIT_OS       = 4'd0;
    localparam logic [3:0] START_RELOAD = 4'd1;
`else
    localparam logic [3:0] START_OS     = 4'd7;
    localparam logic [3:0] BIT_OS       = 4'd15;
    localparam logic [3:0] START_RELOAD = 4'd0;
`endif

    logic             r_rx_meta;
    logic             r_rxs;
    logic             r_prev;
    logic [1:0]       r_warm;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_os_cnt;
    logic [2:0]       r_state;
    logic [3:0]       r_bit_cnt;
    logic [DATA_LENGTH-1:0] r_shift;
    logic             r_perr;
    logic             r_ferr;

    logic w_tick;
    logic w_fall;
    logic w_start_dec;
    logic w_bit_dec;
    logic w_bit;

    // Synchronizer plus edge history. r_warm holds r_prev low until the real
    // line value has crossed both sync stages, so a line that is already low
    // at reset release never looks like a falling edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_prev    <= 1'b0;
            r_warm    <= 2'b00;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
            r_warm    <= {r_warm[0], 1'b1};
            r_prev    <= r_warm[1] & r_rxs;
        end
    end

    assign w_tick      = (r_div_cnt == DIV_W'(DIVIDER - 1));
    assign w_fall      = r_prev & ~r_rxs;
    assign w_start_dec = w_tick && (r_os_cnt == START_OS);
    assign w_bit_dec   = w_tick && (r_os_cnt == BIT_OS);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_vote;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_vote <= 2'b00;
        end else if (w_tick) begin
            if ((r_state == S_START) ? (r_os_cnt == 4'd6) : (r_os_cnt == 4'd14))
                r_vote[0] <= r_rxs;
            if ((r_state == S_START) ? (r_os_cnt == 4'd7) : (r_os_cnt == 4'd15))
                r_vote[1] <= r_rxs;
        end
    end

    assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_rxs) | (r_vote[1] & r_rxs);
`else
    assign w_bit = r_rxs;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_os_cnt   <= '0;
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            active     <= 1'b0;
        end else begin
            valid <= 1'b0;

            // Tick generator; re-phased on start detection
            if (r_state == S_IDLE && w_fall) begin
                r_div_cnt <= '0;
                r_os_cnt  <= '0;
            end else begin
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                if (w_tick)
                    r_os_cnt <= r_os_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        active    <= 1'b1;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_start_dec) begin
                        if (w_bit) begin
                            // false start: glitch shorter than half a bit
                            active  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_os_cnt <= START_RELOAD;
                            r_state  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_bit_dec) begin
                        r_shift <= {w_bit, r_shift[DATA_LENGTH-1:1]};
                        if (r_bit_cnt == 4'(DATA_LENGTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_dec) begin
                        r_perr  <= w_bit ^ (^r_shift) ^ 1'(PARITY);
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_dec) begin
                        if (!w_bit)
                            r_ferr <= 1'b1;
                        if (r_bit_cnt == 4'(STOPBITS - 1))
                            r_state <= S_DONE;
                        else
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Leaves mid stop bit so the next start edge is not missed
                    data       <= r_shift;
                    valid      <= 1'b1;
                    parity_err <= r_perr;
                    frame_err  <= r_ferr;
                    active     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_module.sv
// Directed bench for uart_rx_module: 100 MHz, 781250 baud -> 128 clk/bit.
// u_dut1 uses one stop bit, u_dut2 two stop bits on its own line.
module tb_uart_rx_module;

    localparam int BIT = 128;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       rx, rx2;
    logic [7:0] data1, data2;
    logic       valid1, pe1, fe1, act1;
    logic       valid2, pe2, fe2, act2;

    always #5 clk_in = ~clk_in;

    uart_rx_module #(.BASE_FREQUENCY_MHZ(100), .BAUDRATE(781250), .DATA_LENGTH(8),
                     .STOPBITS(1), .PARITY(0)) u_dut1 (
        .clk_in(clk_in), .reset(reset), .rx(rx), .data(data1), .valid(valid1),
        .parity_err(pe1), .frame_err(fe1), .active(act1));

    uart_rx_module #(.BASE_FREQUENCY_MHZ(100), .BAUDRATE(781250), .DATA_LENGTH(8),
                     .STOPBITS(2), .PARITY(0)) u_dut2 (
        .clk_in(clk_in), .reset(reset), .rx(rx2), .data(data2), .valid(valid2),
        .parity_err(pe2), .frame_err(fe2), .active(act2));

    int n_chk = 0;
    int n_pass = 0;

    // monitor state
    int         cyc = 0;
    int         vcnt1 = 0, vcnt2 = 0;
    int         vcyc1 = 0, pvcyc1 = 0, vcyc2 = 0, pvcyc2 = 0;
    logic [7:0] ld1 = 0, pd1 = 0, ld2 = 0, pd2 = 0;
    logic       lpe1 = 0, lfe1 = 0, lpe2 = 0, lfe2 = 0;
    logic       act_prev1 = 0, act_at_v1 = 0, act_bef_v1 = 0;
    int         act_cyc1 = 0;
    int         start_cyc = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (act1) act_cyc1 = act_cyc1 + 1;
        if (valid1) begin
            vcnt1 = vcnt1 + 1; pvcyc1 = vcyc1; vcyc1 = cyc;
            pd1 = ld1; ld1 = data1; lpe1 = pe1; lfe1 = fe1;
            act_at_v1 = act1; act_bef_v1 = act_prev1;
        end
        if (valid2) begin
            vcnt2 = vcnt2 + 1; pvcyc2 = vcyc2; vcyc2 = cyc;
            pd2 = ld2; ld2 = data2; lpe2 = pe2; lfe2 = fe2;
        end
        act_prev1 = act1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx2 = v; else rx = v;
    endtask

    task automatic hold(input bit sel, input logic v, input int n);
        @(negedge clk_in);
        drive(sel, v);
        repeat (n - 1) @(negedge clk_in);
    endtask

    // gbit >= 0 puts an 8-clk low glitch centred in that data bit
    task automatic send(input bit sel, input logic [7:0] d, input logic pbit,
                        input int nstop, input logic [1:0] stops, input int gbit);
        start_cyc = cyc;
        hold(sel, 1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                hold(sel, d[i], 60); hold(sel, 1'b0, 8); hold(sel, d[i], 60);
            end else begin
                hold(sel, d[i], BIT);
            end
        end
        hold(sel, pbit, BIT);
        for (int s = 0; s < nstop; s++) hold(sel, stops[s], BIT);
    endtask

    task automatic wait_cnt1(input int target);
        for (int k = 0; k < 400 && vcnt1 < target; k++) @(negedge clk_in);
        #2;
    endtask

    task automatic wait_cnt2(input int target);
        for (int k = 0; k < 400 && vcnt2 < target; k++) @(negedge clk_in);
        #2;
    endtask

    initial begin
        int base;
        reset = 1'b1; rx = 1'b1; rx2 = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_data", 32'(data1), 32'h0);
        chk("rst_flags", 32'({valid1, pe1, fe1, act1}), 32'h0);
        @(negedge clk_in); reset = 1'b0;
        repeat (20) @(negedge clk_in);

        // clean frame, even parity
        send(0, 8'hA5, 1'b0, 1, 2'b11, -1);
        wait_cnt1(1);
        chk("a5_cnt", 32'(vcnt1), 32'd1);
        chk("a5_data", 32'(ld1), 32'hA5);
        chk("a5_flags", 32'({lpe1, lfe1}), 32'h0);
        chk("a5_act_at_valid", 32'(act_at_v1), 32'h0);
        chk("a5_act_before", 32'(act_bef_v1), 32'h1);
        chk("a5_in_stop_bit", 32'((vcyc1 - start_cyc) >= 10*BIT && (vcyc1 - start_cyc) < 11*BIT), 32'h1);
        repeat (50) @(negedge clk_in);

        // wrong parity bit
        send(0, 8'h3C, 1'b1, 1, 2'b11, -1);
        wait_cnt1(2);
        chk("3c_cnt", 32'(vcnt1), 32'd2);
        chk("3c_data", 32'(ld1), 32'h3C);
        chk("3c_flags", 32'({lpe1, lfe1}), 32'h2);
        repeat (50) @(negedge clk_in);

        // stop bit low, then break
        send(0, 8'h81, 1'b0, 1, 2'b00, -1);
        wait_cnt1(3);
        chk("81_cnt", 32'(vcnt1), 32'd3);
        chk("81_data", 32'(ld1), 32'h81);
        chk("81_flags", 32'({lpe1, lfe1}), 32'h1);
        repeat (2000) @(negedge clk_in);
        chk("break_no_valid", 32'(vcnt1), 32'd3);
        chk("break_idle", 32'(act1), 32'h0);
        hold(0, 1'b1, 300);
        chk("break_release", 32'(vcnt1), 32'd3);

        // false start: 40 clk low pulse
        act_cyc1 = 0;
        hold(0, 1'b0, 40);
        hold(0, 1'b1, 200);
        chk("fs_no_valid", 32'(vcnt1), 32'd3);
        chk("fs_active_len", 32'(act_cyc1 >= 40 && act_cyc1 <= 80), 32'h1);
        chk("fs_active_off", 32'(act1), 32'h0);
        send(0, 8'h12, 1'b0, 1, 2'b11, -1);
        wait_cnt1(4);
        chk("12_data", 32'(ld1), 32'h12);
        chk("12_flags", 32'({lpe1, lfe1}), 32'h0);
        repeat (50) @(negedge clk_in);

        // reset after data bit 2 of 0xFF; sender abandons the frame
        hold(0, 1'b0, BIT);
        for (int i = 0; i < 3; i++) hold(0, 1'b1, BIT);
        @(negedge clk_in); reset = 1'b1; rx = 1'b1;
        @(posedge clk_in); #1;
        chk("rst_mid_data", 32'(data1), 32'h0);
        chk("rst_mid_flags", 32'({valid1, pe1, fe1, act1}), 32'h0);
        @(negedge clk_in); reset = 1'b0;
        repeat (2000) @(negedge clk_in);
        chk("rst_mid_no_valid", 32'(vcnt1), 32'd4);
        send(0, 8'h5A, 1'b0, 1, 2'b11, -1);
        wait_cnt1(5);
        chk("5a_cnt", 32'(vcnt1), 32'd5);
        chk("5a_data", 32'(ld1), 32'h5A);
        repeat (50) @(negedge clk_in);

        // back-to-back, one stop bit
        send(0, 8'h00, 1'b0, 1, 2'b11, -1);
        send(0, 8'hFF, 1'b0, 1, 2'b11, -1);
        wait_cnt1(7);
        chk("b2b1_cnt", 32'(vcnt1), 32'd7);
        chk("b2b1_first", 32'(pd1), 32'h00);
        chk("b2b1_second", 32'(ld1), 32'hFF);
        chk("b2b1_gap", 32'(vcyc1 - pvcyc1), 32'(11*BIT));
        chk("b2b1_flags", 32'({lpe1, lfe1}), 32'h0);

        // back-to-back, two stop bits
        send(1, 8'h00, 1'b0, 2, 2'b11, -1);
        send(1, 8'hFF, 1'b0, 2, 2'b11, -1);
        wait_cnt2(2);
        chk("b2b2_cnt", 32'(vcnt2), 32'd2);
        chk("b2b2_first", 32'(pd2), 32'h00);
        chk("b2b2_second", 32'(ld2), 32'hFF);
        chk("b2b2_gap", 32'(vcyc2 - pvcyc2), 32'(12*BIT));
        chk("b2b2_flags", 32'({lpe2, lfe2}), 32'h0);

        // second stop bit low must still flag a framing error
        repeat (50) @(negedge clk_in);
        send(1, 8'h6E, 1'b1, 2, 2'b01, -1);
        wait_cnt2(3);
        chk("stop2_data", 32'(ld2), 32'h6E);
        chk("stop2_flags", 32'({lpe2, lfe2}), 32'h1);
        hold(1, 1'b1, 300);
        chk("stop2_cnt", 32'(vcnt2), 32'd3);

`ifdef UART_RX_MAJORITY_EN
        base = vcnt1;
        send(0, 8'hFF, 1'b0, 1, 2'b11, 3);
        wait_cnt1(base + 1);
        chk("glitch_data", 32'(ld1), 32'hFF);
        chk("glitch_flags", 32'({lpe1, lfe1}), 32'h0);
`else
        base = 0;
`endif
        repeat (20) @(negedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
